// File: rtl/uart_tx_if.sv
// Valid/ready word handshake into the UART transmitter.
interface uart_tx_if #(
    parameter int DATA_BITS = 8
);
    logic [DATA_BITS-1:0] tx_data;
    logic                 tx_valid;
    logic                 tx_ready;

    modport master (
        output tx_data,
        output tx_valid,
        input  tx_ready
    );

    modport slave (
        input  tx_data,
        input  tx_valid,
        output tx_ready
    );
endinterface

// File: rtl/uart_tx.sv
// 8N1-style UART transmitter: start bit, LSB-first data, stop bit.
// Line output is registered so the far-side sampler never sees glitches.
module uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int DATA_BITS    = 8
) (
    input  logic      clk,
    input  logic      rstN,
    uart_tx_if.slave  bus,
    output logic      tx,
    output logic      busy
);
    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam int BIT_W = $clog2(DATA_BITS);

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } state_t;

    state_t               state_q, state_d;
    logic [CNT_W-1:0]     clk_cnt_q, clk_cnt_d;
    logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 tx_q, tx_d;
    logic                 bit_end;
    logic                 accept;

    assign bit_end = (clk_cnt_q == CNT_W'(CLKS_PER_BIT - 1));
    assign accept  = bus.tx_valid && (state_q == IDLE);

    always_ff @(posedge clk or negedge rstN) begin
        if (!rstN) begin
            state_q   <= IDLE;
            clk_cnt_q <= '0;
            bit_cnt_q <= '0;
            shift_q   <= '0;
            tx_q      <= 1'b1;
        end else begin
            state_q   <= state_d;
            clk_cnt_q <= clk_cnt_d;
            bit_cnt_q <= bit_cnt_d;
            shift_q   <= shift_d;
            tx_q      <= tx_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        clk_cnt_d = bit_end ? '0 : clk_cnt_q + CNT_W'(1);
        bit_cnt_d = bit_cnt_q;
        shift_d   = shift_q;
        unique case (state_q)
            IDLE: begin
                clk_cnt_d = '0;
                if (accept) begin
                    shift_d   = bus.tx_data;
                    bit_cnt_d = '0;
                    state_d   = START;
                end
            end
            START: begin
                if (bit_end) state_d = DATA;
            end
            DATA: begin
                if (bit_end) begin
                    shift_d   = shift_q >> 1;
                    bit_cnt_d = bit_cnt_q + BIT_W'(1);
                    if (bit_cnt_q == BIT_W'(DATA_BITS - 1))
                        state_d = STOP;
                end
            end
            STOP: begin
                if (bit_end) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // Line level is decoded from the next state so it lands in tx_q
    // on the same edge the state changes.
    always_comb begin
        tx_d = 1'b1;
        unique case (state_d)
            IDLE:    tx_d = 1'b1;
            START:   tx_d = 1'b0;
            DATA:    tx_d = shift_d[0];
            STOP:    tx_d = 1'b1;
            default: tx_d = 1'b1;
        endcase
    end

    assign tx           = tx_q;
    assign bus.tx_ready = (state_q == IDLE);
    assign busy         = (state_q != IDLE);
endmodule

// File: tb/tb_uart_tx.sv
// Directed and random frames against a bit-table line model,
// on a CLKS_PER_BIT=4 instance and a CLKS_PER_BIT=2 instance.
module tb_uart_tx;
    logic       clk = 1'b0;
    logic       rstN = 1'b0;
    logic [7:0] tb_data = 8'h00;
    logic       tb_valid = 1'b0;
    logic       sel = 1'b0;
    int         errors = 0;
    int         checks = 0;
    int         cyc = 0;
    int         acc_cnt = 0;

    always #5 clk = ~clk;

    uart_tx_if #(.DATA_BITS(8)) ifa ();
    uart_tx_if #(.DATA_BITS(8)) ifb ();
    logic tx_a, busy_a, tx_b, busy_b;

    assign ifa.tx_data  = tb_data;
    assign ifb.tx_data  = tb_data;
    assign ifa.tx_valid = sel ? 1'b0 : tb_valid;
    assign ifb.tx_valid = sel ? tb_valid : 1'b0;

    uart_tx #(.CLKS_PER_BIT(4), .DATA_BITS(8)) dut_a (
        .clk(clk), .rstN(rstN), .bus(ifa), .tx(tx_a), .busy(busy_a)
    );
    uart_tx #(.CLKS_PER_BIT(2), .DATA_BITS(8)) dut_b (
        .clk(clk), .rstN(rstN), .bus(ifb), .tx(tx_b), .busy(busy_b)
    );

    logic cur_tx, cur_rdy, cur_busy;
    assign cur_tx   = sel ? tx_b   : tx_a;
    assign cur_rdy  = sel ? ifb.tx_ready : ifa.tx_ready;
    assign cur_busy = sel ? busy_b : busy_a;

    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (rstN && tb_valid && cur_rdy) acc_cnt <= acc_cnt + 1;
    end

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic idle_chk(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            chk("idle_tx", 32'(cur_tx), 1);
            chk("idle_rdy", 32'(cur_rdy), 1);
        end
    endtask

    // Called just after a negedge. Line model: bit slot (c-1)/cpb of
    // {stop, data, start} must be on the line in cycle c after acceptance.
    task automatic run_frame(input logic [7:0] d, input bit hold,
                             input logic [7:0] nd, input bit wiggle,
                             input int abort_at, output int n);
        int         cpb;
        int         f;
        int         acc0;
        logic [9:0] bits;
        cpb  = sel ? 2 : 4;
        f    = 10 * cpb;
        bits = {1'b1, d, 1'b0};
        acc0 = acc_cnt;
        tb_data  = d;
        tb_valid = 1'b1;
        chk("rdy_pre", 32'(cur_rdy), 1);
        @(posedge clk);
        #1;
        n = cyc;
        chk("accept", 32'(acc_cnt), 32'(acc0 + 1));
        if (hold) tb_data = nd;
        else tb_valid = 1'b0;
        for (int c = 1; c <= f; c++) begin
            @(negedge clk);
            if (c == abort_at) begin
                tb_valid = 1'b0;
                #2 rstN = 1'b0;
                #1;
                chk("rst_tx", 32'(cur_tx), 1);
                chk("rst_rdy", 32'(cur_rdy), 1);
                chk("rst_busy", 32'(cur_busy), 0);
                @(negedge clk);
                chk("rst_hold_tx", 32'(cur_tx), 1);
                rstN = 1'b1;
                return;
            end
            if (wiggle) begin
                tb_data  = 8'hFF;
                tb_valid = (c < f) ? ~tb_valid : 1'b0;
            end
            chk("line", 32'(cur_tx), 32'(bits[(c - 1) / cpb]));
            chk("rdy_low", 32'(cur_rdy), 0);
            chk("busy_hi", 32'(cur_busy), 1);
        end
        @(negedge clk);
        chk("gap_tx", 32'(cur_tx), 1);
        chk("rdy_back", 32'(cur_rdy), 1);
        chk("busy_back", 32'(cur_busy), 0);
        chk("one_accept", 32'(acc_cnt), 32'(acc0 + 1));
    endtask

    initial begin
        int n1, n2;
        logic [7:0] r;

        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("reset_tx", 32'(cur_tx), 1);
            chk("reset_rdy", 32'(cur_rdy), 1);
            chk("reset_busy", 32'(cur_busy), 0);
        end
        rstN = 1'b1;
        idle_chk(50);

        run_frame(8'hA5, 1'b0, 8'h00, 1'b0, 0, n1);
        idle_chk(2);

        run_frame(8'h00, 1'b1, 8'hFF, 1'b0, 0, n1);
        run_frame(8'hFF, 1'b0, 8'h00, 1'b0, 0, n2);
        chk("b2b_gap", 32'(n2 - n1), 41);
        idle_chk(3);

        run_frame(8'h3C, 1'b0, 8'h00, 1'b1, 0, n1);
        idle_chk(5);
        chk("no_extra", 32'(acc_cnt), 4);

        run_frame(8'h55, 1'b0, 8'h00, 1'b0, 18, n1);
        run_frame(8'h81, 1'b0, 8'h00, 1'b0, 0, n1);
        idle_chk(1);

        for (int i = 0; i < 6; i++) begin
            r = 8'($urandom);
            run_frame(r, 1'b0, 8'h00, 1'b0, 0, n1);
            idle_chk(int'($urandom_range(0, 4)));
        end

        sel = 1'b1;
        idle_chk(2);
        run_frame(8'h01, 1'b1, 8'h02, 1'b0, 0, n1);
        run_frame(8'h02, 1'b0, 8'h00, 1'b0, 0, n2);
        chk("div2_gap", 32'(n2 - n1), 21);
        r = 8'($urandom);
        run_frame(r, 1'b0, 8'h00, 1'b0, 0, n1);
        idle_chk(2);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
